// File: rtl/alu_ctrl_idex_if.sv
// ID-to-EX bundle for the ALU decode stage: ID-side instruction/operands and
// hazard controls in, registered EX-side ALU operands and pipeline control out.
interface alu_ctrl_idex_if #(
  parameter int DW  = 32,
  parameter int RAW = 5
);
  logic           id_valid;
  logic [31:0]    id_instr;
  logic [DW-1:0]  id_rs_data;
  logic [DW-1:0]  id_rt_data;
  logic           stall;
  logic           flush;

  logic           ex_valid;
  logic [2:0]     ex_aluCtr;
  logic [DW-1:0]  ex_input1;
  logic [DW-1:0]  ex_input2;
  logic [DW-1:0]  ex_store_data;
  logic [RAW-1:0] ex_wreg;
  logic           ex_regwrite;
  logic           ex_memread;
  logic           ex_memwrite;
  logic           ex_branch;
  logic           ex_illegal;

  // The ID stage / hazard unit side drives instructions and stall/flush.
  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
    input  ex_valid, ex_aluCtr, ex_input1, ex_input2, ex_store_data,
           ex_wreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal
  );

  // The ID/EX register itself consumes the ID side and produces the EX side.
  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
    output ex_valid, ex_aluCtr, ex_input1, ex_input2, ex_store_data,
           ex_wreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal
  );
endinterface

// File: rtl/alu_ctrl_idex.sv
// MIPS ID-stage decode into ALU control, operands and EX/MEM/WB enables,
// registered as the ID/EX pipeline register with stall, flush and bubbles.
module alu_ctrl_idex #(
  parameter int         DW      = 32,
  parameter int         RAW     = 5,
  parameter logic [2:0] NOP_CTR = 3'b010
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctrl_idex_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] CTR_AND = 3'b000;
  localparam logic [2:0] CTR_OR  = 3'b001;
  localparam logic [2:0] CTR_ADD = 3'b010;
  localparam logic [2:0] CTR_XOR = 3'b011;
  localparam logic [2:0] CTR_NOR = 3'b100;
  localparam logic [2:0] CTR_SUB = 3'b110;

  logic [5:0]     op;
  logic [5:0]     funct;
  logic [RAW-1:0] rt;
  logic [RAW-1:0] rd;
  logic [15:0]    imm;
  logic [DW-1:0]  immSext;
  logic [DW-1:0]  immZext;
  logic [4:0]     unused_shamt;

  assign op           = bus.id_instr[31:26];
  assign funct        = bus.id_instr[5:0];
  assign rt           = RAW'(bus.id_instr[20:16]);
  assign rd           = RAW'(bus.id_instr[15:11]);
  assign imm          = bus.id_instr[15:0];
  assign immSext      = {{(DW-16){imm[15]}}, imm};
  assign immZext      = {{(DW-16){1'b0}}, imm};
  assign unused_shamt = bus.id_instr[10:6];

  logic [2:0]     dCtr;
  logic [DW-1:0]  dIn2;
  logic [RAW-1:0] dWreg;
  logic           dRegwrite;
  logic           dMemread;
  logic           dMemwrite;
  logic           dBranch;
  logic           dIllegal;

  always_comb begin
    dCtr      = NOP_CTR;
    dIn2      = bus.id_rt_data;
    dWreg     = rt;
    dRegwrite = 1'b0;
    dMemread  = 1'b0;
    dMemwrite = 1'b0;
    dBranch   = 1'b0;
    dIllegal  = 1'b0;

    // The all-zero word is the canonical NOP and keeps the defaults.
    if (bus.id_instr != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          dWreg     = rd;
          dRegwrite = 1'b1;
          case (funct)
            FN_ADD:  dCtr = CTR_ADD;
            FN_SUB:  dCtr = CTR_SUB;
            FN_AND:  dCtr = CTR_AND;
            FN_OR:   dCtr = CTR_OR;
            FN_XOR:  dCtr = CTR_XOR;
            FN_NOR:  dCtr = CTR_NOR;
            default: begin
              dIllegal  = 1'b1;
              dRegwrite = 1'b0;
            end
          endcase
        end
        OP_ADDI: begin
          dCtr      = CTR_ADD;
          dIn2      = immSext;
          dRegwrite = 1'b1;
        end
        OP_ANDI: begin
          dCtr      = CTR_AND;
          dIn2      = immZext;
          dRegwrite = 1'b1;
        end
        OP_ORI: begin
          dCtr      = CTR_OR;
          dIn2      = immZext;
          dRegwrite = 1'b1;
        end
        OP_XORI: begin
          dCtr      = CTR_XOR;
          dIn2      = immZext;
          dRegwrite = 1'b1;
        end
        OP_LW: begin
          dCtr      = CTR_ADD;
          dIn2      = immSext;
          dMemread  = 1'b1;
          dRegwrite = 1'b1;
        end
        OP_SW: begin
          dCtr      = CTR_ADD;
          dIn2      = immSext;
          dMemwrite = 1'b1;
        end
        OP_BEQ: begin
          dCtr    = CTR_SUB;
          dBranch = 1'b1;
        end
        default: dIllegal = 1'b1;
      endcase
    end

    // $0 is hard-wired, so a write to it is dropped here rather than in WB.
    if (dWreg == '0) dRegwrite = 1'b0;

    if (!bus.id_valid) begin
      dCtr      = NOP_CTR;
      dRegwrite = 1'b0;
      dMemread  = 1'b0;
      dMemwrite = 1'b0;
      dBranch   = 1'b0;
      dIllegal  = 1'b0;
    end
  end

  // Flush beats stall; a flush bubble leaves the data fields as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_aluCtr     <= NOP_CTR;
      bus.ex_input1     <= '0;
      bus.ex_input2     <= '0;
      bus.ex_store_data <= '0;
      bus.ex_wreg       <= '0;
      bus.ex_regwrite   <= 1'b0;
      bus.ex_memread    <= 1'b0;
      bus.ex_memwrite   <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_illegal    <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_aluCtr   <= NOP_CTR;
      bus.ex_regwrite <= 1'b0;
      bus.ex_memread  <= 1'b0;
      bus.ex_memwrite <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_illegal  <= 1'b0;
    end else if (!bus.stall) begin
      bus.ex_valid      <= bus.id_valid;
      bus.ex_aluCtr     <= dCtr;
      bus.ex_input1     <= bus.id_rs_data;
      bus.ex_input2     <= dIn2;
      bus.ex_store_data <= bus.id_rt_data;
      bus.ex_wreg       <= dWreg;
      bus.ex_regwrite   <= dRegwrite;
      bus.ex_memread    <= dMemread;
      bus.ex_memwrite   <= dMemwrite;
      bus.ex_branch     <= dBranch;
      bus.ex_illegal    <= dIllegal;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Directed bench for alu_ctrl_idex; control outputs are compared as one packed
// word {valid, aluCtr, regwrite, memread, memwrite, branch, illegal}.
module tb_alu_ctrl_idex;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_ctrl_idex_if #(.DW(32), .RAW(5)) bus ();

  alu_ctrl_idex #(.DW(32), .RAW(5), .NOP_CTR(3'b010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] ctrl;
  assign ctrl = {bus.ex_valid, bus.ex_aluCtr, bus.ex_regwrite, bus.ex_memread,
                 bus.ex_memwrite, bus.ex_branch, bus.ex_illegal};

  localparam logic [8:0] C_BUBBLE = 9'b0_010_00000;

  // Drive one set of ID inputs, let one edge pass, then sample 1 ns later.
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic st, input logic fl);
    bus.id_valid   = v;
    bus.id_instr   = instr;
    bus.id_rs_data = rs;
    bus.id_rt_data = rt;
    bus.stall      = st;
    bus.flush      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (ctrl !== C_BUBBLE) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want %b", ctrl, C_BUBBLE);
    end
    checks++;
    if ({bus.ex_input1, bus.ex_input2, bus.ex_store_data, bus.ex_wreg} !== 101'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h/%h/%h/%h want 0", bus.ex_input1,
               bus.ex_input2, bus.ex_store_data, bus.ex_wreg);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    logic [2:0] ctr [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h0022_1800 | {26'h0, fn[i]}, 32'd5, 32'd7, 1'b0, 1'b0);
      checks++;
      if (ctrl !== {1'b1, ctr[i], 5'b10000}) begin
        errors++;
        $display("[TB] FAIL rtype_ctrl fn=%h got %b want %b", fn[i], ctrl, {1'b1, ctr[i], 5'b10000});
      end
      checks++;
      if ({bus.ex_input1, bus.ex_input2, bus.ex_wreg} !== {32'd5, 32'd7, 5'd3}) begin
        errors++;
        $display("[TB] FAIL rtype_data fn=%h got %0d/%0d/%0d want 5/7/3", fn[i],
                 bus.ex_input1, bus.ex_input2, bus.ex_wreg);
      end
    end
  endtask

  task automatic test_immediate();
    logic [31:0] ins [4] = '{32'h2025_FFFC, 32'h3426_8000, 32'h3026_00FF, 32'h3826_8001};
    logic [2:0]  ctr [4] = '{3'b010, 3'b001, 3'b000, 3'b011};
    logic [31:0] in2 [4] = '{32'hFFFF_FFFC, 32'h0000_8000, 32'h0000_00FF, 32'h0000_8001};
    logic [4:0]  wr  [4] = '{5'd5, 5'd6, 5'd6, 5'd6};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, ins[i], 32'd5, 32'd7, 1'b0, 1'b0);
      checks++;
      if (ctrl !== {1'b1, ctr[i], 5'b10000}) begin
        errors++;
        $display("[TB] FAIL imm_ctrl ins=%h got %b want %b", ins[i], ctrl, {1'b1, ctr[i], 5'b10000});
      end
      checks++;
      if ({bus.ex_input2, bus.ex_wreg} !== {in2[i], wr[i]}) begin
        errors++;
        $display("[TB] FAIL imm_data ins=%h got %h/%0d want %h/%0d", ins[i],
                 bus.ex_input2, bus.ex_wreg, in2[i], wr[i]);
      end
    end
  endtask

  task automatic test_memory_branch();
    applyStimulus(1'b1, 32'hAC22_0010, 32'd5, 32'hAB, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_010_00100 || bus.ex_input2 !== 32'h10 || bus.ex_store_data !== 32'hAB) begin
      errors++;
      $display("[TB] FAIL sw got %b in2=%h sd=%h want %b in2=10 sd=ab", ctrl,
               bus.ex_input2, bus.ex_store_data, 9'b1_010_00100);
    end
    applyStimulus(1'b1, 32'h8C22_0010, 32'd5, 32'hAB, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_010_11000 || bus.ex_wreg !== 5'd2 || bus.ex_input2 !== 32'h10) begin
      errors++;
      $display("[TB] FAIL lw got %b wreg=%0d in2=%h want %b wreg=2 in2=10", ctrl,
               bus.ex_wreg, bus.ex_input2, 9'b1_010_11000);
    end
    applyStimulus(1'b1, 32'h1022_0005, 32'd9, 32'd9, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_110_00010 || bus.ex_input2 !== 32'd9) begin
      errors++;
      $display("[TB] FAIL beq got %b in2=%h want %b in2=9", ctrl, bus.ex_input2, 9'b1_110_00010);
    end
  endtask

  task automatic test_stall_flush();
    applyStimulus(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0085_3022 + i, 32'd100 + i, 32'd200, 1'b1, 1'b0);
      checks++;
      if (ctrl !== 9'b1_010_10000 || {bus.ex_input1, bus.ex_input2, bus.ex_wreg} !== {32'd5, 32'd7, 5'd3}) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc=%0d got %b %0d/%0d/%0d want %b 5/7/3", i, ctrl,
                 bus.ex_input1, bus.ex_input2, bus.ex_wreg, 9'b1_010_10000);
      end
    end
    applyStimulus(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b1);
    checks++;
    if (ctrl !== C_BUBBLE) begin
      errors++;
      $display("[TB] FAIL stall_flush got %b want %b", ctrl, C_BUBBLE);
    end
    applyStimulus(1'b1, 32'h8C22_0010, 32'd5, 32'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8C22_0010, 32'd5, 32'd7, 1'b0, 1'b1);
    checks++;
    if (ctrl !== C_BUBBLE) begin
      errors++;
      $display("[TB] FAIL flush_only got %b want %b", ctrl, C_BUBBLE);
    end
    applyStimulus(1'b0, 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0);
    checks++;
    if (ctrl !== C_BUBBLE) begin
      errors++;
      $display("[TB] FAIL id_invalid got %b want %b", ctrl, C_BUBBLE);
    end
  endtask

  task automatic test_illegal_nop();
    applyStimulus(1'b1, 32'h0022_182A, 32'd5, 32'd7, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_010_00001) begin
      errors++;
      $display("[TB] FAIL illegal_funct got %b want %b", ctrl, 9'b1_010_00001);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b0);
      checks++;
      if (ctrl !== 9'b1_010_00001) begin
        errors++;
        $display("[TB] FAIL illegal_stall cyc=%0d got %b want %b", i, ctrl, 9'b1_010_00001);
      end
    end
    applyStimulus(1'b1, 32'hFC00_0000, 32'd5, 32'd7, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_010_00001) begin
      errors++;
      $display("[TB] FAIL illegal_op got %b want %b", ctrl, 9'b1_010_00001);
    end
    applyStimulus(1'b1, 32'h0000_0000, 32'd5, 32'd7, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_010_00000) begin
      errors++;
      $display("[TB] FAIL nop got %b want %b", ctrl, 9'b1_010_00000);
    end
    applyStimulus(1'b1, 32'h0022_0020, 32'd5, 32'd7, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 9'b1_010_00000) begin
      errors++;
      $display("[TB] FAIL add_rd0 got %b want %b", ctrl, 9'b1_010_00000);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_BUBBLE || {bus.ex_input1, bus.ex_input2, bus.ex_wreg} !== 69'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got %b %0d/%0d/%0d want %b 0/0/0", ctrl,
               bus.ex_input1, bus.ex_input2, bus.ex_wreg, C_BUBBLE);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BUBBLE || bus.ex_input1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_release got %b in1=%0d want %b in1=0", ctrl, bus.ex_input1, C_BUBBLE);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ctrl !== 9'b1_010_10000 || bus.ex_input1 !== 32'd5) begin
      errors++;
      $display("[TB] FAIL first_capture got %b in1=%0d want %b in1=5", ctrl, bus.ex_input1, 9'b1_010_10000);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_instr   = 32'h0;
    bus.id_rs_data = 32'h0;
    bus.id_rt_data = 32'h0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_rtype();
    test_immediate();
    test_memory_branch();
    test_stall_flush();
    test_illegal_nop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
